// File: rtl/adc_capture_if.sv
// Readout stream between the capture block and the measurement/display logic.
// The capture block drives samples as master; the consumer supplies ready as slave.
interface adc_capture_if #(
    parameter int DW = 14
);
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/adc_capture.sv
// Triggered ADC capture: registers the ADC stream, decimates it, waits for a
// trigger, stores a fixed-length record with its min/max, then streams the
// record out over a valid/ready port.
module adc_capture #(
    parameter int DW         = 14,
    parameter int DEPTH_LOG2 = 8,
    parameter int TIMEOUT    = 1048576
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] AD_A,
    output logic          AD_CLK_A,
    input  logic          arm,
    input  logic [7:0]    decim,
    input  logic [1:0]    trig_mode,
    input  logic [DW-1:0] trig_level,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] smp_min,
    output logic [DW-1:0] smp_max,
    adc_capture_if.master rd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    state_t                state;
    logic [DW-1:0]         s_cur;
    logic [DW-1:0]         s_prev;
    logic                  prev_valid;
    logic [DW-1:0]         level_r;
    logic [7:0]            decim_r;
    logic [1:0]            mode_r;
    logic [7:0]            dec_cnt;
    logic [TW-1:0]         to_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  rd_pending;
    logic                  s1_valid;
    logic                  s1_last;
    logic [DW-1:0]         run_min;
    logic [DW-1:0]         run_max;
    logic [DW-1:0]         ram_q;
    logic [DW-1:0]         mem [DEPTH];

    logic                  kept;
    logic                  rise;
    logic                  fall;
    logic                  trig;
    logic                  start;
    logic                  out_load;
    logic                  issue;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DW-1:0]         nxt_min;
    logic [DW-1:0]         nxt_max;

    // The ADC runs directly from the system clock.
    assign AD_CLK_A = clk;

    // Trigger detection, running extremes and the single RAM port's address/enable selection.
    always_comb begin
        kept  = (dec_cnt == 8'd0);
        rise  = prev_valid && (s_prev < level_r) && (s_cur >= level_r);
        fall  = prev_valid && (s_prev > level_r) && (s_cur <= level_r);
        trig  = 1'b0;
        if (state == ARMED && kept) begin
            case (mode_r)
                2'd0:    trig = 1'b1;
                2'd1:    trig = rise;
                2'd2:    trig = fall;
                default: trig = rise || (to_cnt == TO_LAST);
            endcase
        end
        start    = arm && (state == IDLE || state == READOUT);
        nxt_min  = (s_cur < run_min) ? s_cur : run_min;
        nxt_max  = (s_cur > run_max) ? s_cur : run_max;
        out_load = !rd.rd_valid || rd.rd_ready;
        issue    = (state == READOUT) && rd_pending && (!s1_valid || out_load);
        ram_we   = trig || (state == CAPTURE && kept);
        ram_addr = (state == READOUT) ? rd_addr : ((state == ARMED) ? '0 : wr_ptr);
    end

    // Record buffer: single port, registered read so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= s_cur;
        end
        if (issue) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Capture state machine, input register, counters and the two-stage readout pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            smp_min     <= '0;
            smp_max     <= '0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            s_cur       <= '0;
            s_prev      <= '0;
            prev_valid  <= 1'b0;
            level_r     <= '0;
            decim_r     <= '0;
            mode_r      <= '0;
            dec_cnt     <= '0;
            to_cnt      <= '0;
            wr_ptr      <= '0;
            rd_addr     <= '0;
            rd_pending  <= 1'b0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            run_min     <= '0;
            run_max     <= '0;
        end else begin
            s_cur <= AD_A;
            if (state == ARMED || state == CAPTURE) begin
                dec_cnt <= (dec_cnt == decim_r) ? 8'd0 : dec_cnt + 8'd1;
            end
            if (start) begin
                state       <= ARMED;
                busy        <= 1'b1;
                done        <= 1'b0;
                rd.rd_valid <= 1'b0;
                rd.rd_last  <= 1'b0;
                s1_valid    <= 1'b0;
                dec_cnt     <= 8'd0;
                prev_valid  <= 1'b0;
                to_cnt      <= '0;
                decim_r     <= decim;
                mode_r      <= trig_mode;
                level_r     <= trig_level;
            end else begin
                case (state)
                    ARMED: begin
                        if (to_cnt != TO_LAST) begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                        if (trig) begin
                            state   <= CAPTURE;
                            wr_ptr  <= DEPTH_LOG2'(1);
                            run_min <= s_cur;
                            run_max <= s_cur;
                        end else if (kept) begin
                            s_prev     <= s_cur;
                            prev_valid <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (kept) begin
                            run_min <= nxt_min;
                            run_max <= nxt_max;
                            wr_ptr  <= wr_ptr + DEPTH_LOG2'(1);
                            if (wr_ptr == ADDR_LAST) begin
                                state      <= READOUT;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                smp_min    <= nxt_min;
                                smp_max    <= nxt_max;
                                rd_addr    <= '0;
                                rd_pending <= 1'b1;
                                s1_valid   <= 1'b0;
                            end
                        end
                    end
                    READOUT: begin
                        if (rd.rd_valid && rd.rd_ready && rd.rd_last) begin
                            state       <= IDLE;
                            done        <= 1'b0;
                            rd.rd_valid <= 1'b0;
                            rd.rd_last  <= 1'b0;
                            s1_valid    <= 1'b0;
                        end else begin
                            if (issue) begin
                                rd_addr <= rd_addr + DEPTH_LOG2'(1);
                                if (rd_addr == ADDR_LAST) begin
                                    rd_pending <= 1'b0;
                                end
                            end
                            if (out_load) begin
                                rd.rd_valid <= s1_valid;
                                if (s1_valid) begin
                                    rd.rd_data <= ram_q;
                                    rd.rd_last <= s1_last;
                                end
                            end
                            if (issue) begin
                                s1_valid <= 1'b1;
                                s1_last  <= (rd_addr == ADDR_LAST);
                            end else if (out_load) begin
                                s1_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/adc_capture.md
# adc_capture

Triggered sample-capture block for the ADC input channel; the receive-side counterpart to the DAC waveform path. It registers a 14-bit ADC stream and decimates it. It waits for a trigger condition, then stores a fixed-length record in an internal buffer while tracking the record's min/max. The record is then streamed out over a valid/ready interface to the measurement/display logic.

## Interface
Parameters:
- DW, 14, ADC sample width (offset binary)
- DEPTH_LOG2, 8, record length = 2^DEPTH_LOG2 samples
- TIMEOUT, 1048576, auto-trigger timeout in clk cycles

Ports:
- clk  in  1  system clock; also the ADC sample clock
- rst_n  in  1  reset, synchronous, active-low
- AD_A  in  DW  raw ADC data
- AD_CLK_A  out  1  ADC clock, equal to clk
- arm  in  1  single-cycle request to start a capture
- decim  in  8  keep one sample out of every decim+1
- trig_mode  in  2  0 immediate, 1 rising, 2 falling, 3 auto (rising or timeout)
- trig_level  in  DW  trigger threshold
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in READOUT
- rd_data  out  DW  record sample
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  marks the final record sample
- smp_min, smp_max  out  DW  extremes of the last completed record

## Operation
- Input stage: AD_A is registered every cycle into s_cur.
- Decimation counter runs 0..decim and wraps. A "kept" sample occurs when the counter equals 0, so decim=0 keeps every sample.
- decim, trig_mode and trig_level are sampled when arm is accepted. Later changes have no effect until the next arm.
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE: on arm → ARMED. On entry to ARMED:
  - the decimation counter is cleared;
  - the previous-sample-valid flag is cleared;
  - the timeout counter is cleared.
- ARMED: trigger logic is evaluated on kept samples only, with s_prev = the previous kept sample.
  - Mode 0: the first kept sample triggers.
  - Mode 1 triggers on s_prev < trig_level and s_cur >= trig_level.
  - Mode 2 triggers on s_prev > trig_level and s_cur <= trig_level.
  - Mode 3 triggers as mode 1, or when the timeout counter reaches TIMEOUT-1. On a timeout, the next kept sample triggers.
  - Edge modes never trigger on the first kept sample after arm, because no valid s_prev exists yet.
  - Comparisons are unsigned.
- Trigger sample handling: the trigger sample is written to buffer address 0 in the same cycle the trigger is detected. State → CAPTURE, write pointer = 1.
- CAPTURE: each kept sample is written at the write pointer, which then increments.
  - After address 2^DEPTH_LOG2-1 is written, state → READOUT. No wrap-around and no overwrite occur.
- Min/max: at trigger, min/max are seeded with the trigger sample and updated on every stored sample. smp_min/smp_max are copied to the outputs on entry to READOUT and hold until the next READOUT entry.
- READOUT: samples stream out in address order 0..2^DEPTH_LOG2-1. rd_last is high with the final sample.
  - After the transfer with rd_valid & rd_ready & rd_last, state → IDLE.
- arm handling by state:
  - arm in ARMED or CAPTURE is ignored.
  - arm in READOUT aborts the readout: rd_valid drops the next cycle and state → ARMED. smp_min/smp_max keep the last completed values.
- Buffer: single-port inferred RAM, 2^DEPTH_LOG2 × DW, with a 1-cycle read latency.

## Timing
- Reset (rst_n=0 at a clk edge) gives, on the next cycle:
  - state IDLE;
  - busy=0, done=0, rd_valid=0, rd_last=0;
  - rd_data=0, smp_min=0, smp_max=0.
  Reset mid-capture or mid-readout abandons the record.
- AD_A to s_cur takes 1 cycle. The trigger is detected in the cycle that s_cur holds the qualifying sample.
- arm at edge n gives busy=1 from cycle n+1.
- Capture duration after trigger is (2^DEPTH_LOG2-1)·(decim+1) cycles to the last write. done=1 and busy=0 in the following cycle.
- rd_valid first rises at most 2 cycles after done rises (RAM prefetch).
- Handshake: a transfer occurs on any edge with rd_valid & rd_ready.
  - While rd_valid=1 and rd_ready=0, rd_data and rd_last are held stable.
  - With rd_ready held at 1, the block sustains one sample per cycle with no bubbles.
- done falls in the cycle after the last transfer. rd_valid is 0 whenever done=0.
- Timeout counter: counts every cycle in ARMED and saturates at TIMEOUT-1.

## Test plan
- Mode 0, decim=0, AD_A = 0..255 ramp, arm:
  - required: rd_data reads the 256 consecutive ramp values starting at the trigger sample;
  - required: rd_last is high on the 256th; smp_min/smp_max equal the first/last values.
- Mode 1, trig_level=0x2000, triangle wave 0x0000↔0x3FFF, decim=3:
  - required: the first record sample is the first kept sample ≥0x2000 following one <0x2000;
  - required: consecutive record samples are 4 input cycles apart.
- Mode 3, constant AD_A=0x0100, trig_level=0x2000, TIMEOUT=64 (test override), arm:
  - required: the capture starts about 64 cycles after arm;
  - required: all 256 samples equal 0x0100, and smp_min = smp_max = 0x0100.
- Readout backpressure, rd_ready toggled pseudo-randomly:
  - required: rd_data is stable while stalled and there are no lost or duplicated samples;
  - required: done falls after the rd_last transfer.
- arm during CAPTURE is ignored (the record completes normally). arm during READOUT at sample 10 gives rd_valid=0 the next cycle and busy=1.
- rst_n=0 for 1 cycle mid-CAPTURE:
  - required: all outputs return to their reset values the next cycle;
  - required: a subsequent arm in mode 0 produces a correct full record.
